// File: rtl/f36m_cube_root.sv
// Cube root in GF(3^{6M}): undo the cubing coefficient mix, then raise each
// GF(3^{2M}) coefficient to 3^{2M-1} by 2M-1 iterated Frobenius steps.
module f36m_cube_root #(
  localparam int unsigned M  = 97,
  localparam int unsigned W2 = 4 * M - 1,
  localparam int unsigned W6 = 12 * M - 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [W6:0] a,
  output logic [W6:0] c,
  output logic        done
);

  localparam int unsigned W1     = 2 * M - 1;
  localparam int unsigned TAP    = 12;
  localparam int unsigned SPREAD = 3 * M - 2;
  localparam int unsigned CNT_W  = $clog2(2 * M) + 1;

  typedef enum logic [1:0] {LOAD, CUBE, FIN, IDLE} state_t;

  // Trits are 2-bit codes 00=0, 01=1, 10=2; GF(3^M) uses f(x) = x^M + x^TAP + 2.
  function automatic logic [1:0] t_add(input logic [1:0] p, input logic [1:0] q);
    logic [2:0] s;
    s = 3'(p) + 3'(q);
    return (s >= 3'd3) ? 2'(s - 3'd3) : 2'(s);
  endfunction

  function automatic logic [1:0] t_neg(input logic [1:0] p);
    return (p == 2'd1) ? 2'd2 : ((p == 2'd2) ? 2'd1 : 2'd0);
  endfunction

  function automatic logic [W2:0] f32m_add(input logic [W2:0] p, input logic [W2:0] q);
    logic [W2:0] r;
    r = '0;
    for (int i = 0; i < int'(2 * M); i++) r[2*i +: 2] = t_add(p[2*i +: 2], q[2*i +: 2]);
    return r;
  endfunction

  function automatic logic [W2:0] f32m_sub(input logic [W2:0] p, input logic [W2:0] q);
    logic [W2:0] r;
    r = '0;
    for (int i = 0; i < int'(2 * M); i++) r[2*i +: 2] = t_add(p[2*i +: 2], t_neg(q[2*i +: 2]));
    return r;
  endfunction

  // Frobenius: spread trit i to position 3i, then fold x^k = x^(k-M) * (2x^TAP + 1).
  function automatic logic [W1:0] f3m_cubic(input logic [W1:0] p);
    logic [2*SPREAD-1:0] s;
    logic [1:0]          t;
    s = '0;
    for (int i = 0; i < int'(M); i++) s[6*i +: 2] = p[2*i +: 2];
    for (int k = int'(SPREAD) - 1; k >= int'(M); k--) begin
      t = s[2*k +: 2];
      s[2*(k - int'(M) + int'(TAP)) +: 2] = t_add(s[2*(k - int'(M) + int'(TAP)) +: 2], t_neg(t));
      s[2*(k - int'(M)) +: 2]             = t_add(s[2*(k - int'(M)) +: 2], t);
    end
    return s[W1:0];
  endfunction

  // (u + v i)^3 = u^3 - v^3 i, since i^2 = -1.
  function automatic logic [W2:0] f32m_cubic(input logic [W2:0] p);
    logic [W1:0] u3;
    logic [W1:0] v3;
    logic [W1:0] nv3;
    u3  = f3m_cubic(p[W1:0]);
    v3  = f3m_cubic(p[W2:W1+1]);
    nv3 = '0;
    for (int i = 0; i < int'(M); i++) nv3[2*i +: 2] = t_neg(v3[2*i +: 2]);
    return {nv3, u3};
  endfunction

  logic [W2:0]    a0, a1, a2;
  logic [W2:0]    y0, y1, y2;
  logic [W2:0]    x0, x1, x2;
  logic [W2:0]    x0_cube, x1_cube, x2_cube;
  logic [CNT_W-1:0] cnt;
  state_t         state;

  assign {a2, a1, a0} = a;
  assign y2 = a2;
  assign y1 = f32m_add(a1, a2);
  assign y0 = f32m_add(f32m_sub(a0, a1), a2);

  assign x0_cube = f32m_cubic(x0);
  assign x1_cube = f32m_cubic(x1);
  assign x2_cube = f32m_cubic(x2);

  // LOAD holds the freshly loaded operand; its first cycle out of reset is already a cubing step.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD;
      x0    <= y0;
      x1    <= y1;
      x2    <= y2;
      cnt   <= CNT_W'(2 * M - 1);
      done  <= 1'b0;
    end else begin
      case (state)
        LOAD, CUBE: begin
          x0  <= x0_cube;
          x1  <= x1_cube;
          x2  <= x2_cube;
          cnt <= cnt - CNT_W'(1);
          state <= (cnt == CNT_W'(1)) ? FIN : CUBE;
        end
        FIN: begin
          c     <= {x2, x1, x0};
          done  <= 1'b1;
          state <= IDLE;
        end
        IDLE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_f36m_cube_root.sv
// Directed bench for f36m_cube_root: fixed vectors, cubing round trips, restart and hold behaviour.
module tb_f36m_cube_root;

  localparam int M   = 97;
  localparam int TAP = 12;
  localparam int LAT = 2 * M;

  typedef logic [2*M-1:0]  f3m_t;
  typedef logic [4*M-1:0]  f32m_t;
  typedef logic [12*M-1:0] f36m_t;

  logic  clk;
  logic  reset;
  f36m_t a;
  f36m_t c;
  logic  done;

  int errors = 0;
  int checks = 0;

  f36m_cube_root dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .c     (c),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Reference arithmetic: Horner multiplication modulo x^M + x^TAP + 2, i.e. x^M = 2x^TAP + 1.
  function automatic f3m_t f3m_mul(input f3m_t p, input f3m_t q);
    int   r[M];
    int   top;
    f3m_t o;
    for (int j = 0; j < M; j++) r[j] = 0;
    for (int i = M - 1; i >= 0; i--) begin
      top = r[M-1];
      for (int j = M - 1; j > 0; j--) r[j] = r[j-1];
      r[0]   = top % 3;
      r[TAP] = (r[TAP] + 2 * top) % 3;
      for (int j = 0; j < M; j++) r[j] = (r[j] + int'(q[2*i +: 2]) * int'(p[2*j +: 2])) % 3;
    end
    o = '0;
    for (int j = 0; j < M; j++) o[2*j +: 2] = 2'(r[j]);
    return o;
  endfunction

  function automatic f3m_t f3m_neg(input f3m_t p);
    f3m_t o;
    o = '0;
    for (int j = 0; j < M; j++) o[2*j +: 2] = 2'((3 - int'(p[2*j +: 2])) % 3);
    return o;
  endfunction

  function automatic f32m_t f32m_add(input f32m_t p, input f32m_t q);
    f32m_t o;
    o = '0;
    for (int j = 0; j < 2 * M; j++) o[2*j +: 2] = 2'((int'(p[2*j +: 2]) + int'(q[2*j +: 2])) % 3);
    return o;
  endfunction

  function automatic f32m_t f32m_sub(input f32m_t p, input f32m_t q);
    f32m_t o;
    o = '0;
    for (int j = 0; j < 2 * M; j++) o[2*j +: 2] = 2'((int'(p[2*j +: 2]) + 3 - int'(q[2*j +: 2])) % 3);
    return o;
  endfunction

  function automatic f32m_t f32m_cube(input f32m_t p);
    f3m_t lo;
    f3m_t hi;
    lo = p[2*M-1:0];
    hi = p[4*M-1:2*M];
    return {f3m_neg(f3m_mul(f3m_mul(hi, hi), hi)), f3m_mul(f3m_mul(lo, lo), lo)};
  endfunction

  // (c0 + c1 r + c2 r^2)^3 with r^3 = r + 1.
  function automatic f36m_t f36m_cubic(input f36m_t x);
    f32m_t c0;
    f32m_t c1;
    f32m_t c2;
    c0 = f32m_cube(x[4*M-1:0]);
    c1 = f32m_cube(x[8*M-1:4*M]);
    c2 = f32m_cube(x[12*M-1:8*M]);
    return {c2, f32m_sub(c1, c2), f32m_add(f32m_add(c0, c1), c2)};
  endfunction

  function automatic f36m_t rand_f36m();
    f36m_t v;
    v = '0;
    for (int j = 0; j < 6 * M; j++) v[2*j +: 2] = 2'($urandom_range(0, 2));
    return v;
  endfunction

  function automatic int first_diff(input f36m_t p, input f36m_t q);
    for (int j = 0; j < 12 * M; j++) if (p[j] !== q[j]) return j;
    return -1;
  endfunction

  task automatic check_vec(input string tag, input f36m_t obs, input f36m_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed[127:0]=%h expected[127:0]=%h first_diff_bit=%0d",
             tag, obs[127:0], exp[127:0], first_diff(obs, exp));
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One-cycle reset with operand av; returns with reset low, #1 after the sampling edge.
  task automatic start(input f36m_t av);
    a     = av;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Edges from the last reset edge until done is seen; -1 when the budget expires.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= LAT + 20; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    f32m_t one2;
    f32m_t mone2;
    f36m_t xa;
    f36m_t xb;
    f36m_t xv;
    f36m_t av;
    int    lat;
    int    bad;

    clk   = 1'b0;
    reset = 1'b0;
    a     = '0;
    one2  = f32m_t'(1);
    mone2 = f32m_t'(2);
    @(posedge clk);
    #1;

    // zero operand: exact latency and zero result
    start('0);
    check_int("zero_done_after_reset", int'(done), 0);
    wait_done(lat);
    check_int("zero_latency", lat, LAT);
    check_vec("zero_c", c, '0);

    start({f32m_t'(0), f32m_t'(0), one2});
    wait_done(lat);
    check_int("one_latency", lat, LAT);
    check_vec("one_c", c, {f32m_t'(0), f32m_t'(0), one2});

    start({f32m_t'(0), f32m_t'(0), mone2});
    wait_done(lat);
    check_int("mone_latency", lat, LAT);
    check_vec("mone_c", c, {f32m_t'(0), f32m_t'(0), mone2});

    // a2 = one unmixes to all-ones
    start({one2, f32m_t'(0), f32m_t'(0)});
    wait_done(lat);
    check_int("unmix_latency", lat, LAT);
    check_vec("unmix_c", c, {one2, one2, one2});
    check_vec("unmix_recube", f36m_cubic(c), {one2, f32m_t'(0), f32m_t'(0)});

    // cube then cube root returns the original element
    for (int k = 0; k < 200; k++) begin
      xv = rand_f36m();
      start(f36m_cubic(xv));
      wait_done(lat);
      check_int("roundtrip_latency", lat, LAT);
      check_vec("roundtrip_c", c, xv);
    end

    // cube root then cube returns the original operand
    for (int k = 0; k < 10; k++) begin
      av = rand_f36m();
      start(av);
      wait_done(lat);
      check_int("reverse_latency", lat, LAT);
      check_vec("reverse_cubed", f36m_cubic(c), av);
    end

    // restart mid-operation with a new operand
    xa  = rand_f36m();
    xb  = rand_f36m();
    bad = 0;
    start(f36m_cubic(xa));
    for (int n = 0; n < M; n++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) bad++;
    end
    check_int("restart_done_early", bad, 0);
    bad = 0;
    start(f36m_cubic(xb));
    lat = -1;
    for (int n = 1; n <= LAT + 20; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 && c === xa) bad++;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    check_int("restart_latency", lat, LAT);
    check_int("restart_stale_result", bad, 0);
    check_vec("restart_c", c, xb);

    // after done, operand changes without reset are ignored
    for (int n = 0; n < 50; n++) begin
      a = rand_f36m();
      @(posedge clk);
      #1;
      check_vec("hold_c", c, xb);
      check_int("hold_done", int'(done), 1);
    end

    // multi-cycle reset: only the last sampled operand counts
    xv    = rand_f36m();
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      a = (k == 4) ? f36m_cubic(xv) : rand_f36m();
      @(posedge clk);
      #1;
      check_int("multireset_done_low", int'(done), 0);
    end
    reset = 1'b0;
    wait_done(lat);
    check_int("multireset_latency", lat, LAT);
    check_vec("multireset_c", c, xv);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
